vram_blit_master: RTL and testbench
===================================

Name: vram_blit_master

Overview:
- Bus initiator that issues 8-bit CE/DS/RnW/DSACK cycles toward the video controller's CPU-side port, such as VRAM fills and copies.
- Offloads frame clears and buffer copies from the 68030.
- Sits beside the video controller on the same bus and is muxed onto it by board logic while busy.
- Programmed by a start strobe with latched source, destination, length and mode.

Parameters:
TIMEOUT, 1023, max cycles to wait for each DSACK edge before aborting
ADDR_W, 16, bus address width
REG_ADDR, 16'hFFFF, reserved video-register address; the block never accesses it

Ports:
pixClk  input  1  primary clock; all logic on rising edge
nReset  input  1  asynchronous active-low reset
start  input  1  one-cycle launch strobe, sampled only in IDLE
mode  input  1  0 = copy src to dst, 1 = fill dst with fillData
srcAddr  input  16  copy source start address
dstAddr  input  16  destination start address
len  input  16  byte count
fillData  input  8  fill byte
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse (normal or abort)
err  output  1  sticky abort flag
nBusCE  output  1  bus chip enable, active low
nBusDS  output  1  bus data strobe, active low
busRnW  output  1  1 = read, 0 = write
busAddr  output  16  bus address
busDataOut  output  8  write data
busDataOe  output  1  write-data drive enable for the board tristate
busDataIn  input  8  read data from responder
nBusDSACK  input  1  responder acknowledge, active low, same clock domain

Behaviour:
- All outputs registered.
- Reset values: nBusCE=1, nBusDS=1, busRnW=1, busAddr=0, busDataOut=0, busDataOe=0, busy=0, done=0, err=0. State is IDLE.
- Reset asserted mid-transfer releases the bus asynchronously and drops the transfer; nothing resumes.
- States: IDLE, CHK, RD_REQ, RD_WAIT, RD_END, WR_REQ, WR_WAIT, WR_END, FIN.
- IDLE + start:
  - latch srcAddr, dstAddr, len, mode, fillData; clear err.
  - busy=1 next cycle; go to CHK.
  - start while busy is ignored.
- CHK:
  - if remaining count == 0, go to FIN.
  - else if dst == REG_ADDR, or (mode=0 and src == REG_ADDR): set err, go to FIN; no bus cycle is issued.
  - else go to RD_REQ (copy) or WR_REQ (fill).
- RD_REQ (1 cycle): busAddr=src, busRnW=1, nBusCE=0, nBusDS=0. Go to RD_WAIT.
- RD_WAIT:
  - hold outputs.
  - on the first edge sampling nBusDSACK=0, latch busDataIn into the data register; go to RD_END.
- RD_END:
  - nBusCE=1, nBusDS=1.
  - stay until nBusDSACK=1 is sampled, then go to WR_REQ.
- WR_REQ (1 cycle): busAddr=dst, busRnW=0, busDataOut=(mode ? fillData : latched byte), busDataOe=1, nBusCE=0, nBusDS=1.
- WR_WAIT:
  - nBusDS=0 from this cycle on, so DS trails CE by exactly one clock.
  - on sampling nBusDSACK=0, go to WR_END.
- WR_END:
  - nBusCE=1, nBusDS=1, busDataOe=0, busRnW=1.
  - on sampling nBusDSACK=1: src+=1, dst+=1 (mod 2^16 wrap), count-=1; go to CHK.
- Timeout:
  - a counter clears on entry to each WAIT/END state.
  - if it reaches TIMEOUT without the awaited DSACK level: set err, release the bus (CE/DS high, Oe=0), go to FIN.
- FIN: done=1 for exactly one cycle; busy=0 from the same edge; return to IDLE.
- len=0: exactly 2 cycles from start to done; no CE assertion.
- Address wrap: 16'hFFFE+1 would hit REG_ADDR and aborts. Crossing 16'h7FFF to 16'h8000 (chip 0 to chip 1) is legal and continuous.
- Throughput with a zero-wait responder: fill = 4 clocks per byte; copy = 7 clocks per byte.

Test Plan:
- Fill, mode=1, dst=16'h0100, len=4, fillData=8'hA5, responder acks 2 clocks after DS and releases 1 clock after CE rises -> 4 writes to 0100–0103 with data A5; DS falls 1 clock after CE each cycle; done pulses once; err=0.
- Copy, src=16'h8000, dst=16'h0000, len=3, memory holds 11/22/33 -> read 8000, write 0000=11, read 8001, write 0001=22, read 8002, write 0002=33, strictly alternating; busDataOe high only in WR states.
- len=0 -> no CE edge; done 2 clocks after start; busy high for 1 cycle.
- Fill, dst=16'hFFFD, len=4 -> writes FFFD and FFFE only; then err=1, done pulse; FFFF never appears with CE low.
- Responder never acks -> CE/DS held low for TIMEOUT clocks, then released; err=1, done=1; the next start clears err.
- nReset pulsed during WR_WAIT -> nBusCE, nBusDS, busDataOe inactive immediately (asynchronous), busy=0; a later start with the same args completes normally.

Source files
------------

// File: rtl/vram_blit_master_if.sv
// vram_blit_master_if: control and bus signal bundle for the VRAM blit master
//   master modport (the blitter):
//     in : start, mode, srcAddr, dstAddr, len, fillData, busDataIn, nBusDSACK
//     out: busy, done, err, nBusCE, nBusDS, busRnW, busAddr, busDataOut, busDataOe
//   slave modport (CPU-side programmer plus bus responder): the mirror image
interface vram_blit_master_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] srcAddr;
    logic [ADDR_W-1:0] dstAddr;
    logic [15:0]       len;
    logic [7:0]        fillData;
    logic              busy;
    logic              done;
    logic              err;
    logic              nBusCE;
    logic              nBusDS;
    logic              busRnW;
    logic [ADDR_W-1:0] busAddr;
    logic [7:0]        busDataOut;
    logic              busDataOe;
    logic [7:0]        busDataIn;
    logic              nBusDSACK;

    modport master (
        input  start, mode, srcAddr, dstAddr, len, fillData, busDataIn, nBusDSACK,
        output busy, done, err, nBusCE, nBusDS, busRnW, busAddr, busDataOut, busDataOe
    );

    modport slave (
        output start, mode, srcAddr, dstAddr, len, fillData, busDataIn, nBusDSACK,
        input  busy, done, err, nBusCE, nBusDS, busRnW, busAddr, busDataOut, busDataOe
    );
endinterface

// File: rtl/vram_blit_master.sv
// vram_blit_master: 8-bit CE/DS/RnW/DSACK bus initiator for VRAM fills and copies
//   pixClk : clock, all logic on the rising edge
//   nReset : asynchronous active-low reset; releases the bus at once and drops any transfer
//   bus    : vram_blit_master_if.master
//            start/mode/srcAddr/dstAddr/len/fillData  launch strobe and transfer arguments
//            busy/done/err                            transfer status
//            nBusCE/nBusDS/busRnW/busAddr             bus cycle control
//            busDataOut/busDataOe                     write data and tristate enable
//            busDataIn/nBusDSACK                      responder read data and acknowledge
module vram_blit_master #(
    parameter int                TIMEOUT  = 1023,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] REG_ADDR = {ADDR_W{1'b1}}
) (
    input logic                pixClk,
    input logic                nReset,
    vram_blit_master_if.master bus
);
    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHK, S_RD_REQ, S_RD_WAIT, S_RD_END, S_WR_REQ, S_WR_WAIT, S_WR_END, S_FIN
    } state_t;

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_src, w_src, r_dst, w_dst, r_addr, w_addr;
    logic [15:0]       r_cnt, w_cnt;
    logic [7:0]        r_fill, w_fill, r_data, w_data, r_dout, w_dout;
    logic [TMO_W-1:0]  r_tmo, w_tmo;
    logic              r_mode, w_mode, r_err, w_err;
    logic              r_busy, w_busy, r_done, w_done;
    logic              r_ce_n, w_ce_n, r_ds_n, w_ds_n, r_rnw, w_rnw, r_oe, w_oe;
    logic              w_tmo_hit, w_reg_hit;

    assign w_tmo_hit = (r_tmo == TMO_LAST);
    // The reserved video register must never be touched: destination always, source only when copying
    assign w_reg_hit = (r_dst == REG_ADDR) || (!r_mode && (r_src == REG_ADDR));

    always_comb begin
        w_state = r_state;
        w_src   = r_src;
        w_dst   = r_dst;
        w_cnt   = r_cnt;
        w_mode  = r_mode;
        w_fill  = r_fill;
        w_data  = r_data;
        w_err   = r_err;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state = S_CHK;
                    w_src   = bus.srcAddr;
                    w_dst   = bus.dstAddr;
                    w_cnt   = bus.len;
                    w_mode  = bus.mode;
                    w_fill  = bus.fillData;
                    w_err   = 1'b0;
                end
            end
            S_CHK: begin
                if (r_cnt == 16'd0) begin
                    w_state = S_FIN;
                end else if (w_reg_hit) begin
                    w_err   = 1'b1;
                    w_state = S_FIN;
                end else begin
                    w_state = r_mode ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_RD_REQ: w_state = S_RD_WAIT;
            S_RD_WAIT: begin
                if (!bus.nBusDSACK) begin
                    w_data  = bus.busDataIn;
                    w_state = S_RD_END;
                end else if (w_tmo_hit) begin
                    w_err   = 1'b1;
                    w_state = S_FIN;
                end
            end
            S_RD_END: begin
                if (bus.nBusDSACK) begin
                    w_state = S_WR_REQ;
                end else if (w_tmo_hit) begin
                    w_err   = 1'b1;
                    w_state = S_FIN;
                end
            end
            S_WR_REQ: w_state = S_WR_WAIT;
            S_WR_WAIT: begin
                if (!bus.nBusDSACK) begin
                    w_state = S_WR_END;
                end else if (w_tmo_hit) begin
                    w_err   = 1'b1;
                    w_state = S_FIN;
                end
            end
            S_WR_END: begin
                if (bus.nBusDSACK) begin
                    w_src   = r_src + 1'b1;
                    w_dst   = r_dst + 1'b1;
                    w_cnt   = r_cnt - 1'b1;
                    w_state = S_CHK;
                end else if (w_tmo_hit) begin
                    w_err   = 1'b1;
                    w_state = S_FIN;
                end
            end
            S_FIN:   w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    // Outputs are registered, so their next values follow the state being entered
    always_comb begin
        w_ce_n = 1'b1;
        w_ds_n = 1'b1;
        w_rnw  = 1'b1;
        w_oe   = 1'b0;
        w_addr = r_addr;
        w_dout = r_dout;
        case (w_state)
            S_RD_REQ, S_RD_WAIT: begin
                w_addr = r_src;
                w_ce_n = 1'b0;
                w_ds_n = 1'b0;
            end
            S_WR_REQ, S_WR_WAIT: begin
                w_addr = r_dst;
                w_rnw  = 1'b0;
                w_oe   = 1'b1;
                w_ce_n = 1'b0;
                // DS trails CE by one clock on writes so the data is settled first
                w_ds_n = (w_state == S_WR_REQ);
                w_dout = r_mode ? r_fill : r_data;
            end
            default: ;
        endcase
        w_busy = (w_state != S_IDLE) && (w_state != S_FIN);
        w_done = (w_state == S_FIN);
        // Wait counter restarts on every state change and only matters in WAIT/END states
        w_tmo  = (w_state == r_state) ? r_tmo + 1'b1 : '0;
    end

    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_fill  <= '0;
            r_data  <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ce_n  <= 1'b1;
            r_ds_n  <= 1'b1;
            r_rnw   <= 1'b1;
            r_oe    <= 1'b0;
            r_addr  <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state;
            r_src   <= w_src;
            r_dst   <= w_dst;
            r_cnt   <= w_cnt;
            r_mode  <= w_mode;
            r_fill  <= w_fill;
            r_data  <= w_data;
            r_tmo   <= w_tmo;
            r_err   <= w_err;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_ce_n  <= w_ce_n;
            r_ds_n  <= w_ds_n;
            r_rnw   <= w_rnw;
            r_oe    <= w_oe;
            r_addr  <= w_addr;
            r_dout  <= w_dout;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.nBusCE     = r_ce_n;
    assign bus.nBusDS     = r_ds_n;
    assign bus.busRnW     = r_rnw;
    assign bus.busAddr    = r_addr;
    assign bus.busDataOut = r_dout;
    assign bus.busDataOe  = r_oe;
endmodule

// File: tb/tb_vram_blit_master.sv
// tb_vram_blit_master: randomized self-checking bench for vram_blit_master against a transfer-level model
module tb_vram_blit_master;
    localparam int TMO = 31;

    typedef struct {
        bit          rnw;
        logic [15:0] addr;
        logic [7:0]  data;
        int          pre;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vram_blit_master_if #(.ADDR_W(16)) bif();

    vram_blit_master #(.TIMEOUT(TMO), .ADDR_W(16), .REG_ADDR(16'hFFFF)) dut (
        .pixClk(clk),
        .nReset(rst_n),
        .bus   (bif)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:65535];
    txn_t got[$];
    txn_t exp_q[$];

    // Responder: read data straight from memory, ack a programmable delay after DS, release after CE
    int   ack_dly = 2, rel_dly = 1;
    bit   never_ack = 0, zero_wait = 0;
    logic r_ack_n = 1'b1;
    int   rcnt = 0;

    assign bif.busDataIn = mem[bif.busAddr];
    assign bif.nBusDSACK = zero_wait ? bif.nBusDS : r_ack_n;

    always @(posedge clk) begin
        if (!r_ack_n) begin
            if (!bif.nBusCE) rcnt <= 0;
            else if (rcnt >= rel_dly - 1) begin r_ack_n <= 1'b1; rcnt <= 0; end
            else rcnt <= rcnt + 1;
        end else if (!bif.nBusDS && !never_ack) begin
            if (rcnt >= ack_dly - 1) begin r_ack_n <= 1'b0; rcnt <= 0; end
            else rcnt <= rcnt + 1;
        end else begin
            rcnt <= 0;
        end
    end

    // Bus monitor: one record per acknowledged bus cycle, plus protocol counters
    logic prev_ce = 1'b1;
    int   mon_pre = 0;
    bit   logged = 0;
    int   viol = 0, done_cnt = 0, ds_low = 0, busy_cyc = 0, ce_fall = 0;

    always @(negedge clk) begin
        if (!bif.nBusCE) begin
            if (prev_ce) begin mon_pre = 0; logged = 0; ce_fall++; end
            if (bif.nBusDS) mon_pre++;
            else ds_low++;
            if (bif.busAddr == 16'hFFFF) viol++;
            if (!bif.nBusDS && !bif.nBusDSACK && !logged) begin
                logged = 1;
                got.push_back('{bif.busRnW, bif.busAddr, bif.busRnW ? bif.busDataIn : bif.busDataOut, mon_pre});
            end
        end
        if (bif.busDataOe && (bif.nBusCE || bif.busRnW)) viol++;
        if (bif.done) done_cnt++;
        if (bif.busy) busy_cyc++;
        prev_ce = bif.nBusCE;
    end

    // Transfer-level model: the byte-by-byte sequence of reads/writes and the abort flag
    function automatic void model(input bit m, input logic [15:0] s, input logic [15:0] d,
                                  input logic [15:0] l, input logic [7:0] f, output bit e);
        exp_q.delete();
        e = 0;
        for (int i = 0; i < int'(l); i++) begin
            logic [15:0] si, di;
            si = s + 16'(i);
            di = d + 16'(i);
            if (di == 16'hFFFF || (!m && si == 16'hFFFF)) begin e = 1; break; end
            if (!m) exp_q.push_back('{1'b1, si, mem[si], 0});
            exp_q.push_back('{1'b0, di, m ? f : mem[si], 1});
        end
    endfunction

    // Launch one transfer, scramble the inputs afterwards, poke a stray start while busy, wait for done
    task automatic run(input bit m, input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                       input logic [7:0] f, input int limit, output int cyc, output bit ok);
        got.delete();
        viol = 0; done_cnt = 0; ds_low = 0; busy_cyc = 0; ce_fall = 0;
        @(negedge clk);
        bif.mode = m; bif.srcAddr = s; bif.dstAddr = d; bif.len = l; bif.fillData = f;
        bif.start = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        bif.mode = ~m; bif.srcAddr = 16'($urandom); bif.dstAddr = 16'($urandom);
        bif.len = 16'($urandom_range(1, 9)); bif.fillData = 8'($urandom);
        cyc = 0;
        ok = 0;
        while (!ok && cyc < limit) begin
            if (cyc == 1) bif.start = 1'b1;
            @(posedge clk); #1;
            bif.start = 1'b0;
            cyc++;
            ok = bif.done;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bif.start = 0; bif.mode = 0; bif.srcAddr = 0; bif.dstAddr = 0; bif.len = 0; bif.fillData = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bif.nBusCE, bif.nBusDS, bif.busRnW, bif.busDataOe, bif.busy, bif.done, bif.err} !== 7'b1110000) begin
            errors++;
            $display("FAIL reset_ctrl: got CE/DS/RnW/Oe/busy/done/err=%b expected 1110000",
                     {bif.nBusCE, bif.nBusDS, bif.busRnW, bif.busDataOe, bif.busy, bif.done, bif.err});
        end
        checks++;
        if (bif.busAddr !== 16'h0000 || bif.busDataOut !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h dout=%h expected 0000/00", bif.busAddr, bif.busDataOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_directed();
        bit    m, e, ok;
        logic [15:0] s, d, l;
        logic [7:0]  f;
        int    cyc;
        string nm;
        mem[16'h8000] = 8'h11; mem[16'h8001] = 8'h22; mem[16'h8002] = 8'h33;
        ack_dly = 2; rel_dly = 1; never_ack = 0; zero_wait = 0;
        for (int t = 0; t < 3; t++) begin
            case (t)
                0:       begin nm = "fill_0100"; m = 1; s = 16'h0000; d = 16'h0100; l = 4; f = 8'hA5; end
                1:       begin nm = "copy_8000"; m = 0; s = 16'h8000; d = 16'h0000; l = 3; f = 8'h00; end
                default: begin nm = "fill_wrap"; m = 1; s = 16'h0000; d = 16'hFFFD; l = 4; f = 8'h3C; end
            endcase
            model(m, s, d, l, f, e);
            run(m, s, d, l, f, 400, cyc, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL %s done: not seen within 400 cycles", nm); end
            checks++;
            if (got.size() != exp_q.size()) begin
                errors++;
                $display("FAIL %s count: got %0d bus cycles expected %0d", nm, got.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                checks++;
                if (got[i].rnw !== exp_q[i].rnw || got[i].addr !== exp_q[i].addr ||
                    got[i].data !== exp_q[i].data || got[i].pre != exp_q[i].pre) begin
                    errors++;
                    $display("FAIL %s txn%0d: got rnw=%0d addr=%h data=%h ce2ds=%0d expected rnw=%0d addr=%h data=%h ce2ds=%0d",
                             nm, i, got[i].rnw, got[i].addr, got[i].data, got[i].pre,
                             exp_q[i].rnw, exp_q[i].addr, exp_q[i].data, exp_q[i].pre);
                end
            end
            checks++;
            if (bif.err !== e) begin errors++; $display("FAIL %s err: got %b expected %b", nm, bif.err, e); end
            checks++;
            if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses: got %0d expected 1", nm, done_cnt); end
            checks++;
            if (viol != 0) begin errors++; $display("FAIL %s protocol: got %0d violations expected 0", nm, viol); end
        end
    endtask

    task automatic test_len0();
        int cyc;
        bit ok;
        run(1'b1, 16'h1234, 16'h2345, 16'h0000, 8'hFF, 50, cyc, ok);
        checks++;
        if (!ok || cyc != 1) begin errors++; $display("FAIL len0_latency: got %0d edges (done=%b) expected 1", cyc, ok); end
        checks++;
        if (ce_fall != 0) begin errors++; $display("FAIL len0_ce: got %0d CE assertions expected 0", ce_fall); end
        checks++;
        if (busy_cyc != 1) begin errors++; $display("FAIL len0_busy: got %0d busy cycles expected 1", busy_cyc); end
        checks++;
        if (done_cnt != 1 || bif.err !== 1'b0) begin
            errors++;
            $display("FAIL len0_status: got done_pulses=%0d err=%b expected 1/0", done_cnt, bif.err);
        end
    endtask

    task automatic test_throughput();
        int          cyc, per;
        bit          ok, m;
        logic [15:0] l;
        zero_wait = 1;
        for (int t = 0; t < 4; t++) begin
            m   = t[0];
            l   = 16'($urandom_range(1, 8));
            per = m ? 4 : 7;
            run(m, 16'h1000 + 16'($urandom_range(0, 4095)), 16'h4000 + 16'($urandom_range(0, 4095)),
                l, 8'($urandom), 200, cyc, ok);
            checks++;
            if (!ok || cyc != 1 + per * int'(l)) begin
                errors++;
                $display("FAIL tput mode=%0d len=%0d: got %0d edges expected %0d", m, l, cyc, 1 + per * int'(l));
            end
            checks++;
            if (got.size() != (m ? 1 : 2) * int'(l) || bif.err !== 1'b0) begin
                errors++;
                $display("FAIL tput_cycles mode=%0d: got %0d bus cycles err=%b expected %0d err=0",
                         m, got.size(), bif.err, (m ? 1 : 2) * int'(l));
            end
        end
        zero_wait = 0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok;
        never_ack = 1;
        run(1'b1, 16'h0000, 16'h2000, 16'h0002, 8'h77, 300, cyc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo_done: not seen within 300 cycles"); end
        checks++;
        if (ds_low != TMO || ce_fall != 1) begin
            errors++;
            $display("FAIL tmo_hold: got DS low %0d cycles, %0d CE assertions expected %0d and 1", ds_low, ce_fall, TMO);
        end
        checks++;
        if (bif.err !== 1'b1 || done_cnt != 1) begin
            errors++;
            $display("FAIL tmo_status: got err=%b done_pulses=%0d expected 1/1", bif.err, done_cnt);
        end
        checks++;
        if ({bif.nBusCE, bif.nBusDS, bif.busDataOe} !== 3'b110 || got.size() != 0) begin
            errors++;
            $display("FAIL tmo_release: got CE/DS/Oe=%b cycles=%0d expected 110 and 0",
                     {bif.nBusCE, bif.nBusDS, bif.busDataOe}, got.size());
        end
        never_ack = 0;
        run(1'b1, 16'h0000, 16'h2000, 16'h0001, 8'h77, 300, cyc, ok);
        checks++;
        if (!ok || bif.err !== 1'b0 || got.size() != 1) begin
            errors++;
            $display("FAIL tmo_recover: got done=%b err=%b cycles=%0d expected 1/0/1", ok, bif.err, got.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc, n;
        bit ok, e;
        ack_dly = 6;
        got.delete();
        @(negedge clk);
        bif.mode = 1; bif.srcAddr = 0; bif.dstAddr = 16'h0300; bif.len = 3; bif.fillData = 8'h5C;
        bif.start = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        n = 0;
        while (!(bif.nBusDS === 1'b0 && bif.busRnW === 1'b0) && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL rst_mid_reach: write strobe not seen within 50 cycles"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bif.nBusCE, bif.nBusDS, bif.busDataOe, bif.busy} !== 4'b1100) begin
            errors++;
            $display("FAIL rst_mid_async: got CE/DS/Oe/busy=%b expected 1100",
                     {bif.nBusCE, bif.nBusDS, bif.busDataOe, bif.busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bif.busy !== 1'b0 || bif.nBusCE !== 1'b1 || got.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_noresume: got busy=%b CE=%b cycles=%0d expected 0/1/0", bif.busy, bif.nBusCE, got.size());
        end
        ack_dly = 2;
        model(1'b1, 16'h0000, 16'h0300, 16'h0003, 8'h5C, e);
        run(1'b1, 16'h0000, 16'h0300, 16'h0003, 8'h5C, 300, cyc, ok);
        checks++;
        if (!ok || got.size() != exp_q.size() || bif.err !== e) begin
            errors++;
            $display("FAIL rst_mid_rerun: got done=%b cycles=%0d err=%b expected 1/%0d/%b", ok, got.size(), bif.err, exp_q.size(), e);
        end else foreach (exp_q[i]) begin
            checks++;
            if (got[i].addr !== exp_q[i].addr || got[i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL rst_mid_txn%0d: got %h=%h expected %h=%h", i, got[i].addr, got[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_random();
        bit          m, e, ok;
        logic [15:0] s, d, l;
        logic [7:0]  f;
        int          cyc;
        for (int it = 0; it < 14; it++) begin
            m = 1'($urandom);
            l = 16'($urandom_range(0, 5));
            f = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       begin s = 16'hFFF8 + 16'($urandom_range(0, 7)); d = 16'($urandom); end
                1:       begin s = 16'($urandom); d = 16'hFFF9 + 16'($urandom_range(0, 6)); end
                2:       begin s = 16'h7FFC + 16'($urandom_range(0, 7)); d = 16'h7FFD + 16'($urandom_range(0, 5)); end
                default: begin s = 16'($urandom); d = 16'($urandom); end
            endcase
            ack_dly = $urandom_range(1, 3);
            rel_dly = $urandom_range(1, 2);
            model(m, s, d, l, f, e);
            run(m, s, d, l, f, 500, cyc, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand%0d done: not seen within 500 cycles", it); end
            checks++;
            if (got.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d count: got %0d bus cycles expected %0d (mode=%0d src=%h dst=%h len=%0d)",
                         it, got.size(), exp_q.size(), m, s, d, l);
            end else foreach (exp_q[i]) begin
                checks++;
                if (got[i].rnw !== exp_q[i].rnw || got[i].addr !== exp_q[i].addr ||
                    got[i].data !== exp_q[i].data || got[i].pre != exp_q[i].pre) begin
                    errors++;
                    $display("FAIL rand%0d txn%0d: got rnw=%0d addr=%h data=%h ce2ds=%0d expected rnw=%0d addr=%h data=%h ce2ds=%0d",
                             it, i, got[i].rnw, got[i].addr, got[i].data, got[i].pre,
                             exp_q[i].rnw, exp_q[i].addr, exp_q[i].data, exp_q[i].pre);
                end
            end
            checks++;
            if (bif.err !== e || done_cnt != 1 || viol != 0) begin
                errors++;
                $display("FAIL rand%0d status: got err=%b done_pulses=%0d violations=%0d expected %b/1/0",
                         it, bif.err, done_cnt, viol, e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_directed();
        test_len0();
        test_throughput();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
